// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage
//  Description : RV32I load/store unit for the MEM stage. Performs one access
//                per start against a word-wide memory over a req/ready
//                handshake. Optional watchdog enabled by LSU_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0]        c_F3_B      = 3'b000;
    localparam logic [2:0]        c_F3_H      = 3'b001;
    localparam logic [2:0]        c_F3_W      = 3'b010;
    localparam logic [2:0]        c_F3_BU     = 3'b100;
    localparam logic [2:0]        c_F3_HU     = 3'b101;
    localparam logic [ADDR_W-1:0] c_WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_done;
    logic              r_fault;
    logic [31:0]       r_load_data;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;

    logic              w_illegal;
    logic              w_misaligned;
    logic              w_fault;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;
    logic              w_timeout;

    // Request decode works on the live inputs; only the result is registered.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_wstrb      = 4'b0000;
        w_wdata      = store_data;

        if (is_store) begin
            w_illegal = (funct3 > c_F3_W);
        end else begin
            w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end

        case (funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = |addr[1:0];
            default: w_misaligned = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << addr[1:0];
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data;
            end
        endcase

        if (!is_store) begin
            w_wstrb = 4'b0000;
        end

        w_fault = w_illegal || w_misaligned;
    end

    // Lane selection and extension of the returned word.
    always_comb begin
        w_byte     = mem_rdata[{r_off, 3'b000} +: 8];
        w_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_ext = mem_rdata;
        case (r_funct3)
            c_F3_B:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_load_ext = {24'h000000, w_byte};
            c_F3_HU: w_load_ext = {16'h0000, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // The limit cycle is the last one that may still complete normally.
    assign w_timeout = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_load_data <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_funct3    <= funct3;
                        r_off       <= addr[1:0];
                        r_mem_addr  <= addr & c_WORD_MASK;
                        r_load_data <= 32'h0;
                        if (w_fault) begin
                            r_fault     <= 1'b1;
                            r_done      <= 1'b1;
                            r_mem_wstrb <= 4'b0000;
                            r_mem_wdata <= 32'h0;
                            r_state     <= S_RESP;
                        end else begin
                            r_fault     <= 1'b0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store;
                            r_mem_wstrb <= w_wstrb;
                            r_mem_wdata <= w_wdata;
                            r_state     <= S_REQ;
`ifdef LSU_TIMEOUT_EN
                            r_tmo_cnt   <= '0;
`endif
                        end
                    end
                end

                S_REQ: begin
                    if (mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_load_data <= r_mem_we ? 32'h0 : w_load_ext;
                        r_done      <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_fault     <= 1'b1;
                        r_load_data <= 32'h0;
                        r_done      <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        r_tmo_cnt   <= r_tmo_cnt + c_TMO_W'(1);
`endif
                    end
                end

                S_RESP: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign fault     = r_fault;
    assign load_data = r_load_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_stage
//  Description : Self-checking bench for lsu_mem_stage: directed vector table,
//                multi-cycle corner sequences and random ops vs. a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    localparam int TB_TMO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int LAT_MAX = TB_TMO;
`else
    localparam int LAT_MAX = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    lsu_mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] word;
        int          lat;
        int          poke;
        logic        ef;
        logic [3:0]  es;
        logic [31:0] ed;
        logic [31:0] el;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Spec-level reference: size/alignment rules and byte arithmetic on ref_mem.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output logic ef, output logic [3:0] es,
                         output logic [31:0] ed, output logic [31:0] el);
        int     nbytes, off, idx;
        logic   legal;
        longint v, one;
        one    = 1;
        off    = int'(a % 4);
        idx    = int'(a[11:2]);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal  = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        ef     = !legal || ((a % nbytes) != 0);
        es = 4'h0; ed = 32'h0; el = 32'h0;
        if (!ef) begin
            if (st) begin
                es = 4'(((1 << nbytes) - 1) << off);
                ed = (nbytes == 1) ? 32'(sd[7:0]) * 32'h01010101 :
                     (nbytes == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;
                for (int b = 0; b < 4; b++)
                    if (es[b]) ref_mem[idx][8*b +: 8] = ed[8*b +: 8];
            end else begin
                v = longint'(ref_mem[idx]) >> (8 * off);
                v = v % (one << (8 * nbytes));
                if (f3[2] == 1'b0 && nbytes < 4 && v >= (one << (8 * nbytes - 1)))
                    v = v - (one << (8 * nbytes));
                el = v[31:0];
            end
        end
    endtask

    // One complete access; mem_ready rises in the lat-th REQ cycle.
    // poke>0 pulses start (with junk inputs) in that cycle after acceptance.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int lat, input int poke,
                          input logic ef, input logic [3:0] es, input logic [31:0] ed,
                          input logic [31:0] el, input string nm);
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0; is_store = ~st; funct3 = 3'b111; addr = 32'hFFFF_FFFF; store_data = 32'h0;
        if (ef) begin
            @(negedge clk);
            chk({nm, ".fault_done"}, 32'(done), 32'd1);
            chk({nm, ".fault_flag"}, 32'(fault), 32'd1);
            chk({nm, ".fault_ldata"}, load_data, 32'h0);
            chk({nm, ".fault_noreq"}, 32'(mem_req), 32'd0);
            chk({nm, ".fault_busy"}, 32'(busy), 32'd1);
        end else begin
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) begin @(posedge clk); #1; end
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? mem[a[11:2]] : $urandom;
                start     = (k == poke);
                @(negedge clk);
                chk({nm, ".req"}, 32'(mem_req), 32'd1);
                chk({nm, ".maddr"}, mem_addr, a & 32'hFFFF_FFFC);
                chk({nm, ".we"}, 32'(mem_we), 32'(st));
                chk({nm, ".wait_done"}, 32'(done), 32'd0);
                if (st) begin
                    chk({nm, ".wstrb"}, 32'(mem_wstrb), 32'(es));
                    chk({nm, ".wdata"}, mem_wdata, ed);
                end
                if (k == lat && mem_req && mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
            @(posedge clk); #1;
            mem_ready = 1'b0; mem_rdata = $urandom; start = (poke == lat + 1);
            @(negedge clk);
            chk({nm, ".done"}, 32'(done), 32'd1);
            chk({nm, ".fault"}, 32'(fault), 32'd0);
            chk({nm, ".ldata"}, load_data, el);
            chk({nm, ".req_drop"}, 32'(mem_req), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({nm, ".pulse_end"}, 32'(done), 32'd0);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
        chk({nm, ".ldata_hold"}, load_data, el);
        chk({nm, ".fault_hold"}, 32'(fault), 32'(ef));
        chk({nm, ".done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic        ef, st;
        logic [3:0]  es;
        logic [31:0] ed, el, a, sd;
        logic [2:0]  f3;
        int          d0;

        vecs[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 2, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 1, 0, 1'b0, 4'h0, 32'h0, 32'h0000_0080};
        vecs[2]  = '{1'b0, 3'b001, 32'h1002, 32'h0, 32'h80FF_1234, 1, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_80FF};
        vecs[3]  = '{1'b0, 3'b101, 32'h1000, 32'h0, 32'h80FF_1234, 3, 0, 1'b0, 4'h0, 32'h0, 32'h0000_1234};
        vecs[4]  = '{1'b0, 3'b010, 32'h1004, 32'h0, 32'hCAFE_F00D, 1, 0, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D};
        vecs[5]  = '{1'b0, 3'b000, 32'h1001, 32'h0, 32'h80FF_1234, 1, 0, 1'b0, 4'h0, 32'h0, 32'h0000_0012};
        vecs[6]  = '{1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h2001, 32'h0000_00A5, 32'h0, 1, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h2004, 32'h1234_5678, 32'h0, 6, 3, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0006, 32'h0, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h0003, 32'h0, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h0000, 32'h0, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b110, 32'h0000, 32'h0, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[14] = '{1'b1, 3'b000, 32'h2003, 32'h0000_005A, 32'h0, 2, 3, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0};
        vecs[15] = '{1'b1, 3'b001, 32'h2001, 32'h0000_FFFF, 32'h0, 1, 0, 1'b1, 4'h0, 32'h0, 32'h0};

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end

        // Reset state
        #3 rst = 1'b1;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.ldata", load_data, 32'h0);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.we", 32'(mem_we), 32'd0);
        chk("rst.maddr", mem_addr, 32'h0);
        chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst.wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].lat <= LAT_MAX) begin
                if (!vecs[i].st) mem[vecs[i].a[11:2]] = vecs[i].word;
                run_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].lat, vecs[i].poke,
                       vecs[i].ef, vecs[i].es, vecs[i].ed, vecs[i].el, $sformatf("vec%0d", i));
            end
        end

        // Reset while a request is outstanding
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rstreq.req_before", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq.req", 32'(mem_req), 32'd0);
        chk("rstreq.busy", 32'(busy), 32'd0);
        chk("rstreq.done", 32'(done), 32'd0);
        chk("rstreq.we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("rstreq.after_busy", 32'(busy), 32'd0);
            chk("rstreq.after_req", 32'(mem_req), 32'd0);
        end
        chk("rstreq.no_done", 32'(done_cnt - d0), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no mem_ready at all
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h20;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= TB_TMO; k++) begin
            @(negedge clk);
            chk("tmo.req_held", 32'(mem_req), 32'd1);
            chk("tmo.no_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo.done", 32'(done), 32'd1);
        chk("tmo.fault", 32'(fault), 32'd1);
        chk("tmo.ldata", load_data, 32'h0);
        chk("tmo.req", 32'(mem_req), 32'd0);
        mem[32'h20 >> 2] = 32'h0BAD_F00D;
        run_op(1'b0, 3'b010, 32'h20, 32'h0, TB_TMO, 0, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D, "tmo_edge");
`endif

        // Randomised ops against the reference model
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 4095));
            sd = $urandom;
            model(st, f3, a, sd, ef, es, ed, el);
            run_op(st, f3, a, sd, $urandom_range(1, 3), 0, ef, es, ed, el, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
